ct_fcnvt_norm_pipe: RTL and testbench

Multi-lane, 2-stage pipelined normaliser for subnormal source fractions in up-conversion (half->single, half->double, single->double).
- Per lane: finds the leading one, left-justifies the fraction with the hidden bit at the MSB, and computes the exponent code as a per-operation base minus the leading-zero count.
- Sits in the vfalu convert path between operand unpack and result pack.
- Valid/ready elastic handshake on both sides, plus a synchronous flush.

---
 rtl/ct_fcnvt_norm_pkg.sv | 26 ++
 rtl/ct_fcnvt_lzd_lane.sv | 36 +++
 rtl/ct_fcnvt_norm_pipe.sv | 146 ++++++++++++++
 tb/tb_ct_fcnvt_norm_pipe.sv | 209 ++++++++++++++++++++
 4 files changed

// File: rtl/ct_fcnvt_norm_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : ct_fcnvt_norm_pkg
//  Purpose  : Shared constants and helpers for the convert-path subnormal
//             fraction normaliser (leading-zero width, zero-lane result codes,
//             canonical exponent base codes).
//  Ports    : none (package)
//  Revision : 1.0  initial release
// ============================================================================
package ct_fcnvt_norm_pkg;

    // Width of a leading-zero count for a w-bit fraction (counts 0..w-1).
    function automatic int lz_width(input int w);
        return (w > 1) ? $clog2(w) : 1;
    endfunction

    // Result codes driven for a lane whose source fraction is all zero.
    localparam int ZERO_LANE_FRAC = 0;
    localparam int ZERO_LANE_CNT  = 0;

    // Exponent code for a leading one at the fraction MSB, half->single,
    // 6-bit code width.  Further conversion modes add their bases here.
    localparam logic [5:0] HTOS_BASE = 6'h31;

endpackage : ct_fcnvt_norm_pkg
`default_nettype wire

// File: rtl/ct_fcnvt_lzd_lane.sv
`default_nettype none
// ============================================================================
//  Module   : ct_fcnvt_lzd_lane
//  Purpose  : Combinational leading-zero detector for one source fraction.
//  Ports    : i_src   source fraction
//             o_lz    leading zeros counted from bit SRC_W-1 (0 when all-zero)
//             o_zero  source fraction is all zero
//  Revision : 1.0  initial release
// ============================================================================
module ct_fcnvt_lzd_lane
    import ct_fcnvt_norm_pkg::*;
#(
    parameter int SRC_W = 10,
    parameter int LZ_W  = lz_width(SRC_W)
) (
    input  logic [SRC_W-1:0] i_src,
    output logic [LZ_W-1:0]  o_lz,
    output logic             o_zero
);

    // Scan upward; the last set bit seen is the most significant one, so its
    // distance from the MSB wins.  An all-zero source leaves the count at 0,
    // which keeps the value inside 0..SRC_W-1 for any LZ_W.
    always_comb begin
        o_lz = '0;
        for (int i = 0; i < SRC_W; i++) begin
            if (i_src[i]) begin
                o_lz = LZ_W'(SRC_W - 1 - i);
            end
        end
    end

    assign o_zero = ~|i_src;

endmodule : ct_fcnvt_lzd_lane
`default_nettype wire

// File: rtl/ct_fcnvt_norm_pipe.sv
`default_nettype none
// ============================================================================
//  Module   : ct_fcnvt_norm_pipe
//  Purpose  : Multi-lane, two-stage elastic normaliser for subnormal source
//             fractions in the vfalu up-convert path.  S1 registers the
//             operands with per-lane leading-zero counts; S2 registers the
//             left-justified fraction and exponent code (base - lz).
//  Ports    : forever_cpuclk  clock
//             cpurst          synchronous active-high reset
//             pipe_flush      synchronous flush of all in-flight ops
//             in_vld/in_rdy   input handshake
//             in_src          packed source fractions, lane i at [i*SRC_W +: SRC_W]
//             in_exp_base     exponent code for a leading one at bit SRC_W-1
//             out_vld/out_rdy output handshake
//             out_frac        normalised fractions, hidden bit at bit SRC_W
//             out_cnt         exponent codes
//             out_zero        per-lane all-zero source flag
//  Revision : 1.0  initial release
// ============================================================================
module ct_fcnvt_norm_pipe
    import ct_fcnvt_norm_pkg::*;
#(
    parameter int SRC_W = 10,
    parameter int CNT_W = 6,
    parameter int LANES = 4,
    parameter int LZ_W  = lz_width(SRC_W)
) (
    input  logic                       forever_cpuclk,
    input  logic                       cpurst,
    input  logic                       pipe_flush,
    input  logic                       in_vld,
    output logic                       in_rdy,
    input  logic [LANES*SRC_W-1:0]     in_src,
    input  logic [CNT_W-1:0]           in_exp_base,
    output logic                       out_vld,
    input  logic                       out_rdy,
    output logic [LANES*(SRC_W+1)-1:0] out_frac,
    output logic [LANES*CNT_W-1:0]     out_cnt,
    output logic [LANES-1:0]           out_zero
);

    localparam int                c_frac_w    = SRC_W + 1;
    localparam logic [SRC_W:0]    c_zero_frac = c_frac_w'(ZERO_LANE_FRAC);
    localparam logic [CNT_W-1:0]  c_zero_cnt  = CNT_W'(ZERO_LANE_CNT);

    // Stage registers
    logic                        r_s1_vld_q;
    logic [LANES*SRC_W-1:0]      r_s1_src_q;
    logic [CNT_W-1:0]            r_s1_base_q;
    logic [LANES*LZ_W-1:0]       r_s1_lz_q;
    logic [LANES-1:0]            r_s1_zero_q;

    logic                        r_s2_vld_q;
    logic [LANES*c_frac_w-1:0]   r_s2_frac_q;
    logic [LANES*CNT_W-1:0]      r_s2_cnt_q;
    logic [LANES-1:0]            r_s2_zero_q;

    // Combinational next-state / control
    logic                        w_s1_adv;
    logic                        w_s2_adv;
    logic                        w_s1_load;
    logic                        w_s2_load;
    logic                        w_s1_vld_d;
    logic                        w_s2_vld_d;
    logic [LANES*LZ_W-1:0]       w_s1_lz_d;
    logic [LANES-1:0]            w_s1_zero_d;
    logic [LANES*c_frac_w-1:0]   w_s2_frac_d;
    logic [LANES*CNT_W-1:0]      w_s2_cnt_d;

    // Ready chain: a stage advances when it is empty or the next one moves.
    // in_rdy therefore depends combinationally on out_rdy.
    assign w_s2_adv  = ~r_s2_vld_q | out_rdy;
    assign w_s1_adv  = ~r_s1_vld_q | w_s2_adv;
    assign in_rdy    = w_s1_adv & ~pipe_flush;

    assign w_s1_load = in_vld & in_rdy;
    assign w_s2_load = r_s1_vld_q & w_s2_adv & ~pipe_flush;

    assign w_s1_vld_d = pipe_flush ? 1'b0 : (w_s1_adv ? in_vld     : r_s1_vld_q);
    assign w_s2_vld_d = pipe_flush ? 1'b0 : (w_s2_adv ? r_s1_vld_q : r_s2_vld_q);

    for (genvar l = 0; l < LANES; l++) begin : g_lane
        logic [c_frac_w-1:0] w_ext;
        logic [LZ_W-1:0]     w_lz;

        ct_fcnvt_lzd_lane #(
            .SRC_W (SRC_W),
            .LZ_W  (LZ_W)
        ) u_lzd (
            .i_src  (in_src[l*SRC_W +: SRC_W]),
            .o_lz   (w_s1_lz_d[l*LZ_W +: LZ_W]),
            .o_zero (w_s1_zero_d[l])
        );

        // Appending a zero LSB makes the shifted leading one land on bit SRC_W.
        assign w_lz  = r_s1_lz_q[l*LZ_W +: LZ_W];
        assign w_ext = {r_s1_src_q[l*SRC_W +: SRC_W], 1'b0};

        assign w_s2_frac_d[l*c_frac_w +: c_frac_w] =
            r_s1_zero_q[l] ? c_zero_frac : (w_ext << w_lz);

        // Modulo-2^CNT_W subtract; wrap is intentional.
        assign w_s2_cnt_d[l*CNT_W +: CNT_W] =
            r_s1_zero_q[l] ? c_zero_cnt : (r_s1_base_q - CNT_W'(w_lz));
    end

    always_ff @(posedge forever_cpuclk) begin
        if (cpurst) begin
            r_s1_vld_q  <= 1'b0;
            r_s1_src_q  <= '0;
            r_s1_base_q <= '0;
            r_s1_lz_q   <= '0;
            r_s1_zero_q <= '0;
            r_s2_vld_q  <= 1'b0;
            r_s2_frac_q <= '0;
            r_s2_cnt_q  <= '0;
            r_s2_zero_q <= '0;
        end else begin
            r_s1_vld_q <= w_s1_vld_d;
            r_s2_vld_q <= w_s2_vld_d;
            if (w_s1_load) begin
                r_s1_src_q  <= in_src;
                r_s1_base_q <= in_exp_base;
                r_s1_lz_q   <= w_s1_lz_d;
                r_s1_zero_q <= w_s1_zero_d;
            end
            if (w_s2_load) begin
                r_s2_frac_q <= w_s2_frac_d;
                r_s2_cnt_q  <= w_s2_cnt_d;
                r_s2_zero_q <= w_s1_zero_q_passthru(r_s1_zero_q);
            end
        end
    end

    // Zero flags travel unchanged from S1 to S2.
    function automatic logic [LANES-1:0] w_s1_zero_q_passthru(input logic [LANES-1:0] z);
        return z;
    endfunction

    assign out_vld  = r_s2_vld_q;
    assign out_frac = r_s2_frac_q;
    assign out_cnt  = r_s2_cnt_q;
    assign out_zero = r_s2_zero_q;

endmodule : ct_fcnvt_norm_pipe
`default_nettype wire

// File: tb/tb_ct_fcnvt_norm_pipe.sv
`default_nettype none
// ============================================================================
//  Module   : tb_ct_fcnvt_norm_pipe
//  Purpose  : Directed self-checking bench for ct_fcnvt_norm_pipe: reset,
//             per-lane normalisation, exponent wrap, back-to-back streaming,
//             backpressure, flush and reset during a stall.
//  Revision : 1.0  initial release
// ============================================================================
module tb_ct_fcnvt_norm_pipe;

    localparam int SRC_W = 10;
    localparam int CNT_W = 6;
    localparam int LANES = 4;
    localparam int SW    = LANES * SRC_W;
    localparam int FW    = LANES * (SRC_W + 1);
    localparam int CW    = LANES * CNT_W;

    logic           forever_cpuclk;
    logic           cpurst;
    logic           pipe_flush;
    logic           in_vld;
    logic           in_rdy;
    logic [SW-1:0]  in_src;
    logic [CNT_W-1:0] in_exp_base;
    logic           out_vld;
    logic           out_rdy;
    logic [FW-1:0]  out_frac;
    logic [CW-1:0]  out_cnt;
    logic [LANES-1:0] out_zero;

    int n_vec = 0;
    int n_err = 0;

    ct_fcnvt_norm_pipe #(
        .SRC_W (SRC_W),
        .CNT_W (CNT_W),
        .LANES (LANES)
    ) u_dut (
        .forever_cpuclk (forever_cpuclk),
        .cpurst         (cpurst),
        .pipe_flush     (pipe_flush),
        .in_vld         (in_vld),
        .in_rdy         (in_rdy),
        .in_src         (in_src),
        .in_exp_base    (in_exp_base),
        .out_vld        (out_vld),
        .out_rdy        (out_rdy),
        .out_frac       (out_frac),
        .out_cnt        (out_cnt),
        .out_zero       (out_zero)
    );

    initial forever_cpuclk = 1'b0;
    always #5 forever_cpuclk = ~forever_cpuclk;

    // Hand-computed vectors; lane 3 is leftmost in each concatenation.
    logic [SW-1:0]    v_src  [7] = '{
        {10'h000, 10'h001, 10'h155, 10'h200},
        {10'h001, 10'h001, 10'h001, 10'h001},
        {10'h002, 10'h100, 10'h080, 10'h3FF},
        {10'h000, 10'h000, 10'h000, 10'h000},
        {10'h040, 10'h201, 10'h1FF, 10'h0C3},
        {10'h155, 10'h008, 10'h011, 10'h3C5},
        {10'h3FE, 10'h004, 10'h002, 10'h001}};
    logic [CNT_W-1:0] v_base [7] = '{6'h31, 6'h03, 6'h31, 6'h31, 6'h20, 6'h3F, 6'h00};
    logic [FW-1:0]    v_frac [7] = '{
        {11'h000, 11'h400, 11'h554, 11'h400},
        {11'h400, 11'h400, 11'h400, 11'h400},
        {11'h400, 11'h400, 11'h400, 11'h7FE},
        {11'h000, 11'h000, 11'h000, 11'h000},
        {11'h400, 11'h402, 11'h7FC, 11'h618},
        {11'h554, 11'h400, 11'h440, 11'h78A},
        {11'h7FC, 11'h400, 11'h400, 11'h400}};
    logic [CW-1:0]    v_cnt  [7] = '{
        {6'h00, 6'h28, 6'h30, 6'h31},
        {6'h3A, 6'h3A, 6'h3A, 6'h3A},
        {6'h29, 6'h30, 6'h2F, 6'h31},
        {6'h00, 6'h00, 6'h00, 6'h00},
        {6'h1D, 6'h20, 6'h1F, 6'h1E},
        {6'h3E, 6'h39, 6'h3A, 6'h3F},
        {6'h00, 6'h39, 6'h38, 6'h37}};
    logic [LANES-1:0] v_zero [7] = '{4'b1000, 4'b0000, 4'b0000, 4'b1111,
                                     4'b0000, 4'b0000, 4'b0000};

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
        n_vec++;
        if (obs !== exp_v) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp_v);
        end
    endtask

    task automatic tick();
        @(posedge forever_cpuclk);
        #1;
    endtask

    task automatic drive(input int idx);
        in_src      = v_src[idx];
        in_exp_base = v_base[idx];
    endtask

    task automatic chk_res(input string tag, input int idx);
        chk({tag, ".vld"},  64'(out_vld),  64'd1);
        chk({tag, ".frac"}, 64'(out_frac), 64'(v_frac[idx]));
        chk({tag, ".cnt"},  64'(out_cnt),  64'(v_cnt[idx]));
        chk({tag, ".zero"}, 64'(out_zero), 64'(v_zero[idx]));
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        cpurst = 1'b1; pipe_flush = 1'b0; in_vld = 1'b0;
        in_src = '0; in_exp_base = '0; out_rdy = 1'b1;
        tick(); tick();
        cpurst = 1'b0;

        // Reset state
        chk("rst.vld",  64'(out_vld),  64'd0);
        chk("rst.frac", 64'(out_frac), 64'd0);
        chk("rst.cnt",  64'(out_cnt),  64'd0);
        chk("rst.zero", 64'(out_zero), 64'd0);
        chk("rst.rdy",  64'(in_rdy),   64'd1);

        // Basic four-lane op: result follows the S1 then S2 edges
        drive(0); in_vld = 1'b1; tick(); in_vld = 1'b0;
        chk("basic.s1", 64'(out_vld), 64'd0);
        tick(); chk_res("basic", 0);
        tick(); chk("basic.done", 64'(out_vld), 64'd0);

        // Exponent code wraps modulo 64
        drive(1); in_vld = 1'b1; tick(); in_vld = 1'b0;
        tick(); chk_res("wrap", 1);
        tick();

        // Back-to-back: five ops on consecutive cycles
        for (int c = 0; c < 7; c++) begin
            if (c < 5) begin
                drive(2 + c); in_vld = 1'b1;
                chk($sformatf("b2b.rdy%0d", c), 64'(in_rdy), 64'd1);
            end else begin
                in_vld = 1'b0;
            end
            tick();
            if (c >= 1 && c <= 5) chk_res($sformatf("b2b%0d", c - 1), 2 + c - 1);
            else                  chk($sformatf("b2b.idle%0d", c), 64'(out_vld), 64'd0);
        end

        // Backpressure: out_rdy low for four cycles while three ops are offered
        out_rdy = 1'b0;
        drive(0); in_vld = 1'b1; tick();
        drive(4); tick();
        chk_res("bp.head", 0);
        drive(5);
        for (int c = 0; c < 2; c++) begin
            chk($sformatf("bp.rdy%0d", c), 64'(in_rdy), 64'd0);
            tick();
            chk_res($sformatf("bp.hold%0d", c), 0);
        end
        out_rdy = 1'b1; #1;
        chk("bp.release.rdy", 64'(in_rdy), 64'd1);
        tick(); in_vld = 1'b0;
        chk_res("bp.d1", 4);
        tick(); chk_res("bp.d2", 5);
        tick(); chk("bp.empty", 64'(out_vld), 64'd0);

        // Flush with two ops in flight and a third offered alongside
        out_rdy = 1'b0;
        drive(2); in_vld = 1'b1; tick();
        drive(3); tick();
        chk("fl.full", 64'(out_vld), 64'd1);
        drive(4); pipe_flush = 1'b1; #1;
        chk("fl.rdy", 64'(in_rdy), 64'd0);
        tick();
        pipe_flush = 1'b0; in_vld = 1'b0; out_rdy = 1'b1;
        chk("fl.vld", 64'(out_vld), 64'd0);
        for (int c = 0; c < 3; c++) begin
            tick();
            chk($sformatf("fl.quiet%0d", c), 64'(out_vld), 64'd0);
        end
        drive(5); in_vld = 1'b1; tick(); in_vld = 1'b0;
        chk("fl.next.s1", 64'(out_vld), 64'd0);
        tick(); chk_res("fl.next", 5);
        tick(); chk("fl.next.done", 64'(out_vld), 64'd0);

        // Reset during a stall
        out_rdy = 1'b0;
        drive(6); in_vld = 1'b1; tick();
        drive(0); tick(); in_vld = 1'b0;
        chk("rs.stall", 64'(out_vld), 64'd1);
        cpurst = 1'b1; tick(); cpurst = 1'b0;
        chk("rs.vld",  64'(out_vld),  64'd0);
        chk("rs.frac", 64'(out_frac), 64'd0);
        chk("rs.cnt",  64'(out_cnt),  64'd0);
        chk("rs.zero", 64'(out_zero), 64'd0);
        chk("rs.rdy",  64'(in_rdy),   64'd1);
        out_rdy = 1'b1;
        tick(); chk("rs.quiet", 64'(out_vld), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule : tb_ct_fcnvt_norm_pipe
`default_nettype wire
